// File: rtl/data_memory.sv
// Purpose: byte/half/word data RAM for the single-cycle MIPS datapath, with misalignment detection.
// Latency: loads are combinational (zero cycles); stores commit on the rising clock edge.
// Backpressure: none. A faulting store is dropped and AlignErr flags it in the same cycle.
module data_memory #(
    parameter int WIDTH      = 32,  // lane logic below assumes 32-bit words
    parameter int DEPTH_LOG2 = 6
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] WD,
    input  logic             WE,
    input  logic [1:0]       MemSize,
    input  logic             MemSigned,
    output logic [WIDTH-1:0] RD,
    output logic             AlignErr
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] word_idx;
    logic [1:0]            byte_off;
    logic [WIDTH-1:0]      cur_word;
    logic [7:0]            cur_byte;
    logic [15:0]           cur_half;
    logic [3:0]            byte_en;
    logic [WIDTH-1:0]      wr_dat;
    logic                  unused_addr_hi;

    // The upper address bits are intentionally dropped, so addresses wrap modulo the array size.
    assign word_idx       = A[DEPTH_LOG2+1:2];
    assign byte_off       = A[1:0];
    assign unused_addr_hi = ^A[WIDTH-1:DEPTH_LOG2+2];

    // Fault detection depends only on the address and the access size, never on WE or RST.
    always_comb begin
        AlignErr = 1'b0;
        case (MemSize)
            2'b01:   AlignErr = byte_off[0];
            2'b10:   AlignErr = (byte_off != 2'b00);
            2'b11:   AlignErr = 1'b1;
            default: AlignErr = 1'b0;
        endcase
    end

    // Load path: select a little-endian lane or half and extend it. RD is forced to zero on a fault or during reset.
    always_comb begin
        cur_word = mem[word_idx];
        cur_byte = cur_word[{byte_off, 3'b000} +: 8];
        cur_half = byte_off[1] ? cur_word[31:16] : cur_word[15:0];
        RD       = '0;
        if (!RST && !AlignErr) begin
            case (MemSize)
                2'b00:   RD = MemSigned ? {{(WIDTH-8){cur_byte[7]}}, cur_byte}
                                        : {{(WIDTH-8){1'b0}}, cur_byte};
                2'b01:   RD = MemSigned ? {{(WIDTH-16){cur_half[15]}}, cur_half}
                                        : {{(WIDTH-16){1'b0}}, cur_half};
                default: RD = cur_word;
            endcase
        end
    end

    // Store lane enables. Data is replicated across the lanes so every enabled lane takes the right bits.
    always_comb begin
        byte_en = 4'b0000;
        wr_dat  = WD;
        case (MemSize)
            2'b00: begin
                byte_en = 4'b0001 << byte_off;
                wr_dat  = {4{WD[7:0]}};
            end
            2'b01: begin
                byte_en = byte_off[1] ? 4'b1100 : 4'b0011;
                wr_dat  = {2{WD[15:0]}};
            end
            2'b10: begin
                byte_en = 4'b1111;
                wr_dat  = WD;
            end
            default: begin
                byte_en = 4'b0000;
                wr_dat  = WD;
            end
        endcase
    end

    // Array update: an asynchronous clear overrides any store. A faulting store changes no lane.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (WE && !AlignErr) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) begin
                    mem[word_idx][b*8 +: 8] <= wr_dat[b*8 +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_memory.sv
// Directed checks of data_memory: reset clear, byte and half lanes, extension, faults, wrap and read-during-write.
module tb_data_memory;

    logic        CLK = 1'b0;
    logic        RST;
    logic [31:0] A;
    logic [31:0] WD;
    logic        WE;
    logic [1:0]  MemSize;
    logic        MemSigned;
    logic [31:0] RD;
    logic        AlignErr;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [1:0] SZ_B = 2'b00, SZ_H = 2'b01, SZ_W = 2'b10, SZ_X = 2'b11;

    data_memory #(.WIDTH(32), .DEPTH_LOG2(6)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .A         (A),
        .WD        (WD),
        .WE        (WE),
        .MemSize   (MemSize),
        .MemSigned (MemSigned),
        .RD        (RD),
        .AlignErr  (AlignErr)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Drive a store starting at the falling edge and commit it on the next rising edge.
    task automatic store(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] sz);
        @(negedge CLK);
        A = addr; WD = data; MemSize = sz; WE = 1'b1; MemSigned = 1'b0;
        @(posedge CLK);
        #1 WE = 1'b0;
    endtask

    // Combinational load: set the address and size, let it settle, then sample RD.
    task automatic load(input logic [31:0] addr, input logic [1:0] sz, input logic sgn,
                        output logic [31:0] data);
        WE = 1'b0; A = addr; MemSize = sz; MemSigned = sgn;
        #1 data = RD;
    endtask

    logic [31:0] r;

    initial begin
        RST = 1'b1; A = '0; WD = '0; WE = 1'b0; MemSize = SZ_W; MemSigned = 1'b0;
        #3;
        load(32'h0, SZ_W, 1'b0, r);
        chk("reset_rd", r, 32'h0);
        chk("reset_alignerr", {31'b0, AlignErr}, 32'h0);
        A = 32'h31; #1;
        chk("reset_alignerr_live", {31'b0, AlignErr}, 32'h1);
        @(negedge CLK);
        RST = 1'b0;

        // Reset clear, applied between clock edges
        store(32'h10, 32'hDEADBEEF, SZ_W);
        load(32'h10, SZ_W, 1'b0, r);
        chk("store_word", r, 32'hDEADBEEF);
        @(negedge CLK);
        #1 RST = 1'b1;
        #1 load(32'h10, SZ_W, 1'b0, r);
        chk("rd_during_rst", r, 32'h0);
        RST = 1'b0;
        #1 load(32'h10, SZ_W, 1'b0, r);
        chk("async_clear", r, 32'h0);

        // Byte lanes
        store(32'h20, 32'h0, SZ_W);
        store(32'h22, 32'h123456AB, SZ_B);
        load(32'h20, SZ_W, 1'b0, r);
        chk("byte_store_word", r, 32'h00AB0000);
        load(32'h22, SZ_B, 1'b1, r);
        chk("byte_signed", r, 32'hFFFFFFAB);
        load(32'h22, SZ_B, 1'b0, r);
        chk("byte_unsigned", r, 32'h000000AB);
        store(32'h21, 32'hFFFFFF56, SZ_B);
        load(32'h20, SZ_W, 1'b0, r);
        chk("byte_lane1_merge", r, 32'h00AB5600);
        load(32'h23, SZ_B, 1'b1, r);
        chk("byte_lane3_zero", r, 32'h0);

        // Half store
        store(32'h26, 32'h00008001, SZ_H);
        load(32'h24, SZ_W, 1'b0, r);
        chk("half_store_word", r, 32'h80010000);
        load(32'h26, SZ_H, 1'b1, r);
        chk("half_signed", r, 32'hFFFF8001);
        load(32'h26, SZ_H, 1'b0, r);
        chk("half_unsigned", r, 32'h00008001);
        load(32'h24, SZ_H, 1'b1, r);
        chk("half_low", r, 32'h0);

        // Misalignment
        store(32'h30, 32'h55AA55AA, SZ_W);
        @(negedge CLK);
        A = 32'h31; WD = 32'hCAFEF00D; MemSize = SZ_W; WE = 1'b1;
        #1;
        chk("mis_word_err", {31'b0, AlignErr}, 32'h1);
        chk("mis_word_rd", RD, 32'h0);
        @(posedge CLK);
        #1 WE = 1'b0;
        load(32'h30, SZ_W, 1'b0, r);
        chk("mis_word_nowrite", r, 32'h55AA55AA);
        load(32'h33, SZ_H, 1'b0, r);
        chk("mis_half_err", {31'b0, AlignErr}, 32'h1);
        load(32'h32, SZ_H, 1'b0, r);
        chk("half_ok_err", {31'b0, AlignErr}, 32'h0);
        chk("half_ok_rd", r, 32'h000055AA);
        load(32'h30, SZ_X, 1'b0, r);
        chk("illegal_size_err", {31'b0, AlignErr}, 32'h1);
        chk("illegal_size_rd", r, 32'h0);

        // Wrap and read-during-write
        store(32'h100, 32'h11111111, SZ_W);
        load(32'h000, SZ_W, 1'b0, r);
        chk("wrap_read", r, 32'h11111111);
        @(negedge CLK);
        A = 32'h0; WD = 32'h22222222; MemSize = SZ_W; WE = 1'b1;
        #1;
        chk("rdw_before", RD, 32'h11111111);
        @(posedge CLK);
        #1;
        chk("rdw_after", RD, 32'h22222222);
        WE = 1'b0;

        // Reset asserted in the same cycle as a store wins
        @(negedge CLK);
        A = 32'h40; WD = 32'h0000FFFF; MemSize = SZ_W; WE = 1'b1;
        #1 RST = 1'b1;
        @(posedge CLK);
        #1 RST = 1'b0; WE = 1'b0;
        load(32'h40, SZ_W, 1'b0, r);
        chk("rst_vs_store", r, 32'h0);
        load(32'h24, SZ_W, 1'b0, r);
        chk("rst_clears_all", r, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
